// File: rtl/ii_rect_sum_reader.sv
`default_nettype none
// ============================================================================
// Module      : ii_rect_sum_reader
// Description : Fetches the four integral-image corners of a rectangle and
//               returns the pixel sum D - B - C + A as a one-cycle strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module ii_rect_sum_reader #(
  parameter int II_WIDTH   = 160,
  parameter int II_HEIGHT  = 120,
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rect_x,
  input  logic [7:0]        rect_y,
  input  logic [7:0]        rect_w,
  input  logic [7:0]        rect_h,
  output logic              busy,
  output logic [ADDR_W-1:0] ii_rdaddr,
  output logic              ii_rden,
  input  logic [DATA_W-1:0] ii_rddata,
  output logic              sum_valid,
  output logic [DATA_W-1:0] sum,
  output logic              rect_err
);

  localparam logic [1:0] c_drain_last = 2'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0]        r_cnt;
  logic [7:0]        r_x1;
  logic [7:0]        r_y1;
  logic [7:0]        r_xm1;
  logic [7:0]        r_ym1;
  logic              r_xz;
  logic              r_yz;
  logic              r_ii_rden;
  logic [ADDR_W-1:0] r_ii_rdaddr;
  logic              r_sign;
  logic [RD_LATENCY-1:0] r_pv;
  logic [RD_LATENCY-1:0] r_ps;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_sum;
  logic              r_sum_valid;
  logic              r_rect_err;

  logic [8:0]        w_xend;
  logic [8:0]        w_yend;
  logic              w_bad;
  logic              w_idle;
  logic              w_accept;
  logic              w_reject;
  logic              w_to_done;
  logic              w_issue;
  logic              w_nvalid;
  logic              w_nsign;
  logic [7:0]        w_nx;
  logic [7:0]        w_ny;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_acc_nxt;

  // Nine-bit sums so that x0+w and y0+h cannot wrap before the bound check.
  assign w_xend   = {1'b0, rect_x} + {1'b0, rect_w};
  assign w_yend   = {1'b0, rect_y} + {1'b0, rect_h};
  assign w_bad    = (rect_w == 8'd0) || (rect_h == 8'd0) ||
                    (w_xend > 9'(II_WIDTH)) || (w_yend > 9'(II_HEIGHT));
  assign w_idle   = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
  assign w_accept = w_idle && start && !w_bad;
  assign w_reject = w_idle && start && w_bad;
  assign w_to_done = (r_state == S_DRAIN) && (r_cnt == c_drain_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          w_state_nxt = w_bad ? S_ERR : S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (r_cnt == 2'd3) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_cnt == c_drain_last) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Corner for the slot presented next cycle: D comes straight from the
  // request inputs on accept, B/C/A from the latched coordinates.
  always_comb begin
    w_issue  = 1'b0;
    w_nvalid = 1'b0;
    w_nsign  = 1'b0;
    w_nx     = r_x1;
    w_ny     = r_y1;
    if (w_accept) begin
      w_issue  = 1'b1;
      w_nvalid = 1'b1;
      w_nx     = rect_x + rect_w - 8'd1;
      w_ny     = rect_y + rect_h - 8'd1;
    end else if ((r_state == S_ISSUE) && (r_cnt != 2'd3)) begin
      w_issue = 1'b1;
      case (r_cnt)
        2'd0: begin
          w_nx     = r_x1;
          w_ny     = r_ym1;
          w_nvalid = !r_yz;
          w_nsign  = 1'b1;
        end
        2'd1: begin
          w_nx     = r_xm1;
          w_ny     = r_y1;
          w_nvalid = !r_xz;
          w_nsign  = 1'b1;
        end
        default: begin
          w_nx     = r_xm1;
          w_ny     = r_ym1;
          w_nvalid = !(r_xz || r_yz);
          w_nsign  = 1'b0;
        end
      endcase
    end
  end

  generate
    if (II_WIDTH == 160) begin : g_addr_shift
      assign w_addr = (ADDR_W'(w_ny) << 7) + (ADDR_W'(w_ny) << 5) + ADDR_W'(w_nx);
    end else begin : g_addr_mul
      assign w_addr = (ADDR_W'(w_ny) * ADDR_W'(II_WIDTH)) + ADDR_W'(w_nx);
    end
  endgenerate

  assign w_acc_nxt = !r_pv[RD_LATENCY-1] ? r_acc :
                     r_ps[RD_LATENCY-1]  ? (r_acc - ii_rddata) : (r_acc + ii_rddata);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= 2'd0;
      r_x1        <= 8'd0;
      r_y1        <= 8'd0;
      r_xm1       <= 8'd0;
      r_ym1       <= 8'd0;
      r_xz        <= 1'b0;
      r_yz        <= 1'b0;
      r_ii_rden   <= 1'b0;
      r_ii_rdaddr <= '0;
      r_sign      <= 1'b0;
      r_pv        <= '0;
      r_ps        <= '0;
      r_acc       <= '0;
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
      r_rect_err  <= 1'b0;
    end else begin
      r_ii_rden   <= w_issue && w_nvalid;
      r_ii_rdaddr <= (w_issue && w_nvalid) ? w_addr : '0;
      r_sign      <= w_nsign;
      // Return tags travel alongside the RAM pipeline so masked slots add 0.
      r_pv[0] <= r_ii_rden;
      r_ps[0] <= r_sign;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_ps[i] <= r_ps[i-1];
      end
      r_sum_valid <= w_to_done || w_reject;
      r_rect_err  <= w_reject;
      if (w_reject) begin
        r_sum <= '0;
      end else if (w_to_done) begin
        r_sum <= w_acc_nxt;
      end
      if (w_accept) begin
        r_acc <= '0;
        r_cnt <= 2'd0;
        r_x1  <= rect_x + rect_w - 8'd1;
        r_y1  <= rect_y + rect_h - 8'd1;
        r_xm1 <= rect_x - 8'd1;
        r_ym1 <= rect_y - 8'd1;
        r_xz  <= (rect_x == 8'd0);
        r_yz  <= (rect_y == 8'd0);
      end else begin
        r_acc <= w_acc_nxt;
        if (r_state == S_ISSUE) begin
          r_cnt <= (r_cnt == 2'd3) ? 2'd0 : r_cnt + 2'd1;
        end else if (r_state == S_DRAIN) begin
          r_cnt <= r_cnt + 2'd1;
        end
      end
    end
  end

  assign busy      = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign ii_rden   = r_ii_rden;
  assign ii_rdaddr = r_ii_rdaddr;
  assign sum_valid = r_sum_valid;
  assign sum       = r_sum;
  assign rect_err  = r_rect_err;

endmodule
`default_nettype wire

// File: tb/tb_ii_rect_sum_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ii_rect_sum_reader
// Description : Directed bench over an all-ones image, II(x,y)=(x+1)(y+1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ii_rect_sum_reader;

  localparam int c_w = 160;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rect_x;
  logic [7:0]  rect_y;
  logic [7:0]  rect_w;
  logic [7:0]  rect_h;
  logic        busy;
  logic [14:0] ii_rdaddr;
  logic        ii_rden;
  logic [31:0] ii_rddata;
  logic        sum_valid;
  logic [31:0] sum;
  logic        rect_err;

  int total = 0;
  int bad   = 0;

  ii_rect_sum_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rect_x    (rect_x),
    .rect_y    (rect_y),
    .rect_w    (rect_w),
    .rect_h    (rect_h),
    .busy      (busy),
    .ii_rdaddr (ii_rdaddr),
    .ii_rden   (ii_rden),
    .ii_rddata (ii_rddata),
    .sum_valid (sum_valid),
    .sum       (sum),
    .rect_err  (rect_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ii_val(input logic [14:0] a);
    int x;
    int y;
    x = int'(a) % c_w;
    y = int'(a) / c_w;
    return 32'((x + 1) * (y + 1));
  endfunction

  // Garbage on idle slots exposes any unmasked return.
  always @(posedge clk) begin
    if (ii_rden) ii_rddata <= ii_val(ii_rdaddr);
    else         ii_rddata <= 32'hDEADBEEF;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [7:0]  w;
    logic [7:0]  h;
    logic        err;
    logic [31:0] s;
    logic [3:0]  rd;
    logic [14:0] a0;
    logic [14:0] a1;
    logic [14:0] a2;
    logic [14:0] a3;
  } vec_t;

  function automatic vec_t mk(input int x, input int y, input int w, input int h,
                              input bit err, input int s, input logic [3:0] rd,
                              input int a0, input int a1, input int a2, input int a3);
    vec_t v;
    v.x = 8'(x); v.y = 8'(y); v.w = 8'(w); v.h = 8'(h);
    v.err = err; v.s = 32'(s); v.rd = rd;
    v.a0 = 15'(a0); v.a1 = 15'(a1); v.a2 = 15'(a2); v.a3 = 15'(a3);
    return v;
  endfunction

  task automatic drive_rect(input int x, input int y, input int w, input int h);
    rect_x = 8'(x); rect_y = 8'(y); rect_w = 8'(w); rect_h = 8'(h);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          sv_n;
    int          sv_cnt;
    int          busy_bad;
    int          rd_extra;
    logic [31:0] sv_sum;
    logic        sv_err;
    logic [3:0]  rd_seen;
    logic [14:0] ad [4];
    logic [14:0] ea [4];
    logic        exp_busy;
    sv_n = 0; sv_cnt = 0; busy_bad = 0; rd_extra = 0;
    sv_sum = 32'd0; sv_err = 1'b0; rd_seen = 4'd0;
    ea[0] = v.a0; ea[1] = v.a1; ea[2] = v.a2; ea[3] = v.a3;
    @(negedge clk);
    drive_rect(int'(v.x), int'(v.y), int'(v.w), int'(v.h));
    start = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n <= 4) begin
        rd_seen[4-n] = ii_rden;
        ad[n-1]      = ii_rdaddr;
      end else if (ii_rden) begin
        rd_extra++;
      end
      exp_busy = !v.err && (n <= 5);
      if (busy !== exp_busy) busy_bad++;
      if (sum_valid) begin
        sv_cnt++;
        if (sv_n == 0) begin
          sv_n = n; sv_sum = sum; sv_err = rect_err;
        end
      end
    end
    check($sformatf("v%0d_valid_cycle", idx), 32'(sv_n), v.err ? 32'd1 : 32'd6);
    check($sformatf("v%0d_valid_count", idx), 32'(sv_cnt), 32'd1);
    check($sformatf("v%0d_sum", idx), sv_sum, v.s);
    check($sformatf("v%0d_err", idx), 32'(sv_err), 32'(v.err));
    check($sformatf("v%0d_busy_errors", idx), 32'(busy_bad), 32'd0);
    check($sformatf("v%0d_rden_slots", idx), 32'(rd_seen), 32'(v.rd));
    check($sformatf("v%0d_rden_late", idx), 32'(rd_extra), 32'd0);
    for (int k = 0; k < 4; k++) begin
      if (v.rd[3-k] && rd_seen[3-k]) begin
        check($sformatf("v%0d_addr_slot%0d", idx, k), 32'(ad[k]), 32'(ea[k]));
      end
    end
  endtask

  vec_t vecs [10];

  initial begin
    int sv_cnt;

    vecs[0] = mk(10, 20,   5,   4, 1'b0,    20, 4'b1111,  3694,  3054,  3689,  3049);
    vecs[1] = mk( 0,  0, 160, 120, 1'b0, 19200, 4'b1000, 19199,     0,     0,     0);
    vecs[2] = mk( 0,  0,   1,   1, 1'b0,     1, 4'b1000,     0,     0,     0,     0);
    vecs[3] = mk( 5,  0,   3,   2, 1'b0,     6, 4'b1010,   167,     0,   164,     0);
    vecs[4] = mk(159,119,  1,   1, 1'b0,     1, 4'b1111, 19199, 19039, 19198, 19038);
    vecs[5] = mk( 0,  7,   3,   2, 1'b0,     6, 4'b1100,  1282,   962,     0,     0);
    vecs[6] = mk(150, 0,  11,   1, 1'b1,     0, 4'b0000,     0,     0,     0,     0);
    vecs[7] = mk( 0,  0,   0,   5, 1'b1,     0, 4'b0000,     0,     0,     0,     0);
    vecs[8] = mk( 0,115,   1,   6, 1'b1,     0, 4'b0000,     0,     0,     0,     0);
    vecs[9] = mk(159, 0,   1, 120, 1'b0,   120, 4'b1010, 19199,     0, 19198,     0);

    rst = 1'b1;
    start = 1'b0;
    drive_rect(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rden", 32'(ii_rden), 32'd0);
    check("reset_addr", 32'(ii_rdaddr), 32'd0);
    check("reset_sum_valid", 32'(sum_valid), 32'd0);
    check("reset_sum", sum, 32'd0);
    check("reset_err", 32'(rect_err), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Start held high: second request must be taken in the first's result cycle.
    @(negedge clk);
    drive_rect(10, 20, 5, 4);
    start = 1'b1;
    sv_cnt = 0;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      if (n == 1) drive_rect(0, 0, 1, 1);
      if (n == 7) start = 1'b0;
      if (sum_valid) begin
        sv_cnt++;
        if (sv_cnt == 1) begin
          check("b2b_first_cycle", 32'(n), 32'd6);
          check("b2b_first_sum", sum, 32'd20);
        end else if (sv_cnt == 2) begin
          check("b2b_second_cycle", 32'(n), 32'd12);
          check("b2b_second_sum", sum, 32'd1);
        end
      end
    end
    check("b2b_valid_count", 32'(sv_cnt), 32'd2);

    // Start pulsed while busy is dropped.
    @(negedge clk);
    drive_rect(10, 20, 5, 4);
    start = 1'b1;
    sv_cnt = 0;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 3) begin
        drive_rect(0, 0, 1, 1);
        start = 1'b1;
      end
      if (n == 4) start = 1'b0;
      if (sum_valid) begin
        sv_cnt++;
        if (sv_cnt == 1) begin
          check("busy_start_cycle", 32'(n), 32'd6);
          check("busy_start_sum", sum, 32'd20);
        end
      end
    end
    check("busy_start_count", 32'(sv_cnt), 32'd1);

    // Reset in the middle of the issue phase aborts the request.
    @(negedge clk);
    drive_rect(10, 20, 5, 4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_rden", 32'(ii_rden), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_addr", 32'(ii_rdaddr), 32'd0);
    rst = 1'b0;
    sv_cnt = 0;
    for (int n = 0; n < 10; n++) begin
      if (sum_valid) sv_cnt++;
      @(negedge clk);
    end
    check("abort_no_valid", 32'(sv_cnt), 32'd0);
    run_vec(vecs[1], 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ii_rect_sum_reader.md
# ii_rect_sum_reader

Read-side counterpart of the integral-image capture path. Given a rectangle (x, y, w, h) in the 160x120 integral image (II) held in block RAM, it fetches the four corner II words over the read port. It returns the pixel sum D − B − C + A as a single-cycle result. It sits between the II block RAM read port and the Haar-feature evaluation logic, which issues one rectangle per request.

## Interface
Parameters:
- II_WIDTH, 160, image width in pixels; II word for pixel (x,y) is at address y*II_WIDTH + x
- II_HEIGHT, 120, image height in pixels
- ADDR_W, 15, II RAM address width
- DATA_W, 32, II RAM data width and result width
- RD_LATENCY, 1, read latency of the II RAM in cycles (1 or 2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request strobe; accepted only when busy=0
- rect_x  in  8  left column x0
- rect_y  in  8  top row y0
- rect_w  in  8  width in pixels
- rect_h  in  8  height in pixels
- busy  out  1  request in progress
- ii_rdaddr  out  ADDR_W  II RAM read address
- ii_rden  out  1  II RAM read enable
- ii_rddata  in  DATA_W  II RAM read data, valid RD_LATENCY cycles after ii_rden
- sum_valid  out  1  one-cycle result strobe
- sum  out  DATA_W  rectangle sum; held until next sum_valid
- rect_err  out  1  qualifies sum_valid: rectangle rejected

## Operation
- Corner definitions: x1 = x0+w−1 and y1 = y0+h−1.
  - D = II(x1,y1)
  - B = II(x1,y0−1)
  - C = II(x0−1,y1)
  - A = II(x0−1,y0−1)
  - Any corner with a −1 coordinate is 0. No read is issued for it (ii_rden=0 in its slot), and its returned value is masked to 0.
- Validation at accept: w=0, h=0, x0+w>II_WIDTH, or y0+h>II_HEIGHT → reject. Comparisons use 9-bit widths so they cannot wrap.
- Address = y*II_WIDTH + x. It is computed as (y<<7)+(y<<5)+x for the default width, or a generic multiply otherwise, and is registered.
- Accumulator: DATA_W bits, modulo 2^DATA_W. D and A add; B and C subtract. It clears on accept.
- Request inputs are latched on accept and may change afterwards.
- FSM states:
  - IDLE: start=1 → ISSUE, or → ERR if rejected.
  - ISSUE: 4 cycles, slot counter 0..3, issuing D, B, C, A in that order. → DRAIN.
  - DRAIN: RD_LATENCY cycles collecting returns. → DONE.
  - DONE: pulse sum_valid. → IDLE.
  - ERR: pulse sum_valid with rect_err=1 and sum=0. → IDLE.
- A return slot is tagged by a RD_LATENCY-deep shift register of {valid, sign}, so masked slots contribute 0.
- start while busy=1 is ignored; there is no queueing.

## Timing
- Reset values:
  - busy=0, ii_rden=0, ii_rdaddr=0
  - sum_valid=0, sum=0, rect_err=0
  - state IDLE, accumulator 0
- Start is sampled at the edge ending cycle T (busy=0).
- Valid request:
  - busy=1 from T+1.
  - ii_rdaddr/ii_rden carry the D, B, C, A slots in cycles T+1..T+4.
  - Data for the slot in cycle k is sampled at the end of cycle k+RD_LATENCY.
  - sum_valid=1 in cycle T+5+RD_LATENCY (T+6 for the default); busy=0 in that same cycle.
  - A new start can be accepted in that cycle, giving back-to-back throughput of one rectangle per 5+RD_LATENCY cycles.
- Rejected request: busy stays 0, sum_valid=1 and rect_err=1 in T+1, sum=0, no ii_rden.
- rect_err=0 whenever sum_valid carries a valid result.
- ii_rden is high only in ISSUE cycles for non-masked corners.
- Reset mid-operation: next cycle all outputs take their reset values. In-flight returns are discarded, and no sum_valid is produced for the aborted request.

## Test plan
Bench RAM model: RD_LATENCY=1, loaded with an all-ones image, so II(x,y)=(x+1)(y+1).
- Rect (10,20,5,4), start at T → reads at addresses 3694, 3054, 3689, 3049 in T+1..T+4; sum_valid in T+6 with sum=20, rect_err=0.
- Rect (0,0,160,120) → only the D read is enabled (address 19199); sum=19200.
- Rect (0,0,1,1) → one read at address 0, sum=1. Rect (5,0,3,2) → two reads (D, C), sum=6.
- Rect (150,0,11,1) and rect (0,0,0,5) → rect_err=1 and sum_valid in T+1, sum=0, ii_rden never asserted, busy never asserted.
- Back-to-back: start held high for two requests → second accepted in the first's sum_valid cycle. A start pulsed while busy → ignored, and exactly one sum_valid is produced per accepted request.
- Assert rst in cycle T+3 of a request → ii_rden=0 and busy=0 next cycle, no sum_valid. A fresh request after reset → correct sum.
